// File: rtl/rr_arbiter_if.sv
// Handshake bundle between requesters and the round-robin arbiter.
// The arbiter uses the slave modport; the requester side uses master.
interface rr_arbiter_if #(
  parameter int N     = 8,
  parameter int IDX_W = 3
);
  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             empty;
  logic             timeout;

  modport master (
    output req, done,
    input  grant, grant_idx, grant_valid, empty, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_idx, grant_valid, empty, timeout
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: registered one-hot grant plus binary index, held until
// done, request drop or hold timeout, with one idle bubble between grants.
//
// state   | meaning
// S_IDLE  | no owner; arbitrate req descending from ptr each cycle
// S_GRANT | owner idx_q holds the resource until a release condition
module rr_arbiter #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter_if.slave  bus
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [7:0]       hold_q, hold_d;
  logic             empty_q, empty_d;
  logic             timeout_q, timeout_d;

  logic             win_vld;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  logic             own_req;
  logic             at_limit;
  logic             release_now;

  // Circular descending search starting at ptr; wrap is explicit so that
  // non-power-of-two N never visits indices >= N.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = ptr_q;
    for (int i = 0; i < N; i++) begin
      if (!win_vld && bus.req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
      cand = (cand == '0) ? IDX_W'(N - 1) : cand - IDX_W'(1);
    end
  end

  always_comb begin
    own_req     = bus.req[idx_q];
    at_limit    = (MAX_HOLD != 0) && (hold_q == 8'(MAX_HOLD));
    release_now = bus.done || !own_req || at_limit;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    empty_d   = empty_q;
    timeout_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        empty_d = !win_vld;
        if (win_vld) begin
          state_d          = S_GRANT;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          idx_d            = win_idx;
          hold_d           = 8'd1;
          ptr_d            = (win_idx == '0) ? IDX_W'(N - 1) : win_idx - IDX_W'(1);
        end
      end
      S_GRANT: begin
        if (release_now) begin
          state_d   = S_IDLE;
          grant_d   = '0;
          idx_d     = '0;
          hold_d    = 8'd0;
          // Flag only a revocation the owner did not ask for.
          timeout_d = at_limit && !bus.done && own_req;
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      ptr_q     <= IDX_W'(N - 1);
      hold_q    <= 8'd0;
      empty_q   <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      empty_q   <= empty_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = (state_q == S_GRANT);
  assign bus.empty       = empty_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: expected grant order is queued as requests are driven
// and checked by a monitor each time a new grant appears.
module tb_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n;

  rr_arbiter_if #(.N(8), .IDX_W(3)) ifa ();
  rr_arbiter_if #(.N(5), .IDX_W(3)) ifb ();

  rr_arbiter #(.N(8), .IDX_W(3), .MAX_HOLD(4)) u_a (
    .clk   (clk),
    .rst_n (rst_a_n),
    .bus   (ifa.slave)
  );

  rr_arbiter #(.N(5), .IDX_W(3), .MAX_HOLD(0)) u_b (
    .clk   (clk),
    .rst_n (rst_b_n),
    .bus   (ifb.slave)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic inv(input string tag, input logic [7:0] g, input logic [2:0] idx, input logic v);
    logic ok;
    ok = $onehot0(g) && (v == (|g)) && (v ? (g == (8'd1 << idx)) : (idx == 3'd0));
    chk(tag, 32'(ok), 32'd1);
  endtask

  typedef struct {
    int idx;
    int gap;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // gap = idle cycles expected before this grant; -1 leaves it unchecked
  initial begin
    int   idle_a, idle_b;
    logic pv_a, pv_b;
    exp_t e;
    idle_a = 0; idle_b = 0; pv_a = 1'b0; pv_b = 1'b0;
    forever begin
      @(negedge clk);
      inv("a_inv", ifa.grant, ifa.grant_idx, ifa.grant_valid);
      inv("b_inv", {3'b000, ifb.grant}, ifb.grant_idx, ifb.grant_valid);
      if (ifa.grant_valid && !pv_a) begin
        if (qa.size() == 0) chk("a_unexpected_grant", 32'(qa.size()), 32'd1);
        else begin
          e = qa.pop_front();
          chk("a_idx", 32'(ifa.grant_idx), e.idx);
          if (e.gap >= 0) chk("a_gap", idle_a, e.gap);
        end
        idle_a = 0;
      end else if (!ifa.grant_valid) idle_a++;
      if (ifb.grant_valid && !pv_b) begin
        if (qb.size() == 0) chk("b_unexpected_grant", 32'(qb.size()), 32'd1);
        else begin
          e = qb.pop_front();
          chk("b_idx", 32'(ifb.grant_idx), e.idx);
          if (e.gap >= 0) chk("b_gap", idle_b, e.gap);
        end
        idle_b = 0;
      end else if (!ifb.grant_valid) idle_b++;
      pv_a = ifa.grant_valid;
      pv_b = ifb.grant_valid;
    end
  end

  task automatic a_wait();
    int k;
    k = 0;
    while (!ifa.grant_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (!ifa.grant_valid) chk("a_wait_grant", 32'(ifa.grant_valid), 32'd1);
  endtask

  task automatic b_wait();
    int k;
    k = 0;
    while (!ifb.grant_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (!ifb.grant_valid) chk("b_wait_grant", 32'(ifb.grant_valid), 32'd1);
  endtask

  task automatic a_serve(input int extra);
    a_wait();
    repeat (extra) begin @(posedge clk); #1; end
    if (extra > 0) chk("a_held", 32'(ifa.grant_valid), 32'd1);
    ifa.done = 1'b1;
    @(posedge clk); #1;
    ifa.done = 1'b0;
    chk("a_released", 32'(ifa.grant_valid), 32'd0);
  endtask

  task automatic b_serve();
    b_wait();
    ifb.done = 1'b1;
    @(posedge clk); #1;
    ifb.done = 1'b0;
    chk("b_released", 32'(ifb.grant_valid), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int to_seen;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    ifa.req = '0; ifa.done = 1'b0;
    ifb.req = '0; ifb.done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("a_rst_grant", 32'(ifa.grant), 32'd0);
    chk("a_rst_idx",   32'(ifa.grant_idx), 32'd0);
    chk("a_rst_valid", 32'(ifa.grant_valid), 32'd0);
    chk("a_rst_empty", 32'(ifa.empty), 32'd1);
    chk("a_rst_to",    32'(ifa.timeout), 32'd0);
    chk("b_rst_empty", 32'(ifb.empty), 32'd1);

    // two requesters alternate
    ifa.req = 8'h81;
    qa.push_back('{idx: 7, gap: -1});
    qa.push_back('{idx: 0, gap: 1});
    qa.push_back('{idx: 7, gap: 1});
    rst_a_n = 1'b1;
    a_serve(0);
    a_serve(0);
    a_serve(0);
    ifa.req = '0;
    repeat (2) begin @(posedge clk); #1; end
    chk("a_empty_idle", 32'(ifa.empty), 32'd1);
    chk("a_idle_valid", 32'(ifa.grant_valid), 32'd0);

    // full rotation from a fresh pointer
    rst_a_n = 1'b0;
    @(posedge clk); #1;
    rst_a_n = 1'b1;
    ifa.req = 8'hFF;
    qa.push_back('{idx: 7, gap: -1});
    for (int i = 6; i >= 0; i--) qa.push_back('{idx: i, gap: 1});
    qa.push_back('{idx: 7, gap: 1});
    for (int i = 0; i < 9; i++) a_serve(1);
    ifa.req = '0;
    repeat (2) begin @(posedge clk); #1; end

    // hold timeout after 4 cycles, then bubble and regrant
    ifa.req = 8'h04;
    qa.push_back('{idx: 2, gap: -1});
    qa.push_back('{idx: 2, gap: 1});
    a_wait();
    chk("a_to_idx",   32'(ifa.grant_idx), 32'd2);
    chk("a_to_empty", 32'(ifa.empty), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("a_hold_valid", 32'(ifa.grant_valid), 32'd1);
      chk("a_hold_to",    32'(ifa.timeout), 32'd0);
    end
    @(posedge clk); #1;
    chk("a_to_pulse", 32'(ifa.timeout), 32'd1);
    chk("a_to_valid", 32'(ifa.grant_valid), 32'd0);
    @(posedge clk); #1;
    chk("a_to_clear",   32'(ifa.timeout), 32'd0);
    chk("a_regrant",    32'(ifa.grant_valid), 32'd1);
    chk("a_regrant_ix", 32'(ifa.grant_idx), 32'd2);
    ifa.req = '0;
    @(posedge clk); #1;
    chk("a_drop_valid", 32'(ifa.grant_valid), 32'd0);
    chk("a_drop_to",    32'(ifa.timeout), 32'd0);

    // owner 5 drops its request
    @(posedge clk); #1;
    ifa.req = 8'h20;
    qa.push_back('{idx: 5, gap: -1});
    a_wait();
    @(posedge clk); #1;
    chk("a_own5_held", 32'(ifa.grant_valid), 32'd1);
    ifa.req = '0;
    @(posedge clk); #1;
    chk("a_own5_valid", 32'(ifa.grant_valid), 32'd0);
    chk("a_own5_to",    32'(ifa.timeout), 32'd0);

    // done lands on the timeout edge
    @(posedge clk); #1;
    ifa.req = 8'h20;
    qa.push_back('{idx: 5, gap: -1});
    a_wait();
    repeat (3) begin @(posedge clk); #1; end
    ifa.done = 1'b1;
    @(posedge clk); #1;
    chk("a_both_valid", 32'(ifa.grant_valid), 32'd0);
    chk("a_both_to",    32'(ifa.timeout), 32'd0);
    ifa.done = 1'b0;
    ifa.req = '0;

    // asynchronous reset mid-grant restores ptr to N-1
    @(posedge clk); #1;
    ifa.req = 8'h02;
    qa.push_back('{idx: 1, gap: -1});
    a_wait();
    @(posedge clk); #2;
    ifa.req = 8'h03;
    rst_a_n = 1'b0;
    #1;
    chk("a_arst_grant", 32'(ifa.grant), 32'd0);
    chk("a_arst_valid", 32'(ifa.grant_valid), 32'd0);
    chk("a_arst_idx",   32'(ifa.grant_idx), 32'd0);
    qa.push_back('{idx: 1, gap: -1});
    #6;
    rst_a_n = 1'b1;
    a_wait();
    chk("a_post_rst_idx", 32'(ifa.grant_idx), 32'd1);
    a_serve(0);
    ifa.req = '0;

    // N=5, timeout disabled, pointer wraps 0 -> 4
    @(posedge clk); #1;
    rst_b_n = 1'b1;
    ifb.req = 5'b00001;
    qb.push_back('{idx: 0, gap: -1});
    qb.push_back('{idx: 4, gap: 1});
    qb.push_back('{idx: 0, gap: 1});
    b_wait();
    to_seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      to_seen += int'(ifb.timeout);
    end
    chk("b_long_valid", 32'(ifb.grant_valid), 32'd1);
    chk("b_long_to",    32'(to_seen), 32'd0);
    ifb.req = 5'b10001;
    @(posedge clk); #1;
    chk("b_ignore_other", 32'(ifb.grant_idx), 32'd0);
    b_serve();
    b_serve();
    b_serve();
    ifb.req = '0;

    repeat (3) begin @(posedge clk); #1; end
    chk("a_queue_left", 32'(qa.size()), 32'd0);
    chk("b_queue_left", 32'(qb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
